// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: writer tag layout and forward-select constants.
// Tag fields are sized to fixed maxima so one struct serves any parameterisation
// of the scoreboard; the top zero-extends its narrower indices into them.
package hazard_pkg;
  localparam int MAX_REG_W   = 8;
  localparam int MAX_RDY_W   = 4;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 wr;
    logic [MAX_REG_W-1:0] dest;
    logic [MAX_RDY_W-1:0] ready;
  } tag_t;
endpackage

// File: rtl/hazard_scoreboard_match.sv
// One-operand youngest-match finder: scans the shadow tag array for the nearest
// writer of src and decides whether its result is too late for this operand.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int RDY_W = 2
) (
  input  tag_t             tags [DEPTH],
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             early,
  output logic [RDY_W-1:0] sel,
  output logic             hazard,
  output logic             early_hazard
);
  logic [MAX_REG_W-1:0] src_x;
  logic [MAX_RDY_W-1:0] rdy_m;
  logic [MAX_RDY_W-1:0] pos;
  logic                 hit;

  assign src_x = MAX_REG_W'(src);

  // Scan oldest to youngest so the smallest matching position wins.
  always_comb begin
    sel   = '0;
    rdy_m = '0;
    hit   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tags[i].wr && tags[i].dest == src_x && src != '0) begin
        hit   = 1'b1;
        sel   = RDY_W'(i + 1);
        rdy_m = tags[i].ready;
      end
    end
    pos = MAX_RDY_W'(sel);
    // Early consumers have no path from the producing stage's output, so equality also stalls.
    hazard       = used && hit && (early ? (pos <= rdy_m) : (pos < rdy_m));
    early_hazard = hazard && early;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding/hazard controller beside ID. Tracks writer tags for every stage after
// ID, produces ID and EX forward selects plus the load-use / early-use stall.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int RDY_W    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]         id_use,
  input  logic [NUM_SRC-1:0]         id_early,
  input  logic                       id_wr_en,
  input  logic [REG_W-1:0]           id_wr_dest,
  input  logic [RDY_W-1:0]           id_ready,
  input  logic                       id_flush,
  input  logic                       ext_stall,
  output logic                       stall,
  output logic [NUM_SRC*RDY_W-1:0]   id_fwd_sel,
  output logic [NUM_SRC*RDY_W-1:0]   ex_fwd_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cycles,
  output logic [31:0]                perf_early_stalls
`endif
);
  localparam logic [RDY_W-1:0] DEPTH_R = RDY_W'(DEPTH);

  tag_t                            tags [DEPTH];
  logic [NUM_SRC-1:0][RDY_W-1:0]   sel;
  logic [NUM_SRC-1:0][RDY_W-1:0]   ex_q;
  logic [NUM_SRC-1:0]              haz;
  logic [NUM_SRC-1:0]              ehaz;
  logic                            issue;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
    hazard_match #(.DEPTH(DEPTH), .REG_W(REG_W), .RDY_W(RDY_W)) u_match (
      .tags         (tags),
      .src          (id_src[k*REG_W +: REG_W]),
      .used         (id_use[k]),
      .early        (id_early[k]),
      .sel          (sel[k]),
      .hazard       (haz[k]),
      .early_hazard (ehaz[k])
    );
  end

  // A flush kills the ID instruction, so it can never be the one that stalls.
  assign stall      = !reset && id_valid && !id_flush && (|haz);
  assign id_fwd_sel = reset ? '0 : sel;
  assign issue      = id_valid && !stall && !id_flush;
  assign ex_fwd_sel = ex_q;

  // Shadow pipeline: shift tags one stage per non-frozen edge, inject issued tag or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < DEPTH; p++) tags[p] <= '0;
      ex_q <= '0;
    end else if (!ext_stall) begin
      for (int p = DEPTH - 1; p > 0; p--) tags[p] <= tags[p-1];
      tags[0] <= issue ? tag_t'{wr: id_wr_en, dest: MAX_REG_W'(id_wr_dest),
                                ready: MAX_RDY_W'(id_ready)}
                       : '0;
      // The producer moves one stage while the consumer enters EX; WB drops out
      // because the regfile is write-first.
      for (int k = 0; k < NUM_SRC; k++) begin
        if (issue && sel[k] != '0 && sel[k] < DEPTH_R) ex_q[k] <= sel[k] + 1'b1;
        else                                            ex_q[k] <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic early_only;
  assign early_only = stall && !(|(haz & ~ehaz));

  // Saturating counters of real (non-frozen) stall cycles and early-use-only stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_early_stalls <= '0;
    end else if (stall && !ext_stall) begin
      if (perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (early_only && perf_early_stalls != '1) perf_early_stalls <= perf_early_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios with
// hand-computed expectations, then randomized traffic against a position-list model.
module tb_hazard_scoreboard;
  localparam int D  = 3;
  localparam int RW = 5;
  localparam int DW = 2;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [NS*RW-1:0] id_src;
  logic [NS-1:0]   id_use, id_early;
  logic            id_wr_en;
  logic [RW-1:0]   id_wr_dest;
  logic [DW-1:0]   id_ready;
  logic            id_flush, ext_stall;
  logic            stall;
  logic [NS*DW-1:0] id_fwd_sel, ex_fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     perf_stall_cycles, perf_early_stalls;
`endif

  int checks = 0;
  int errors = 0;
  bit run_chk = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_use(id_use),
    .id_early(id_early), .id_wr_en(id_wr_en), .id_wr_dest(id_wr_dest), .id_ready(id_ready),
    .id_flush(id_flush), .ext_stall(ext_stall), .stall(stall), .id_fwd_sel(id_fwd_sel),
    .ex_fwd_sel(ex_fwd_sel)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_early_stalls(perf_early_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Model: occupant of each stage position 1..D after ID.
  bit m_wr   [1:D];
  int m_dest [1:D];
  int m_rdy  [1:D];
  int m_ex   [NS];
  longint m_pstall = 0, m_pearly = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int src_of(int k);
    return int'(id_src[k*RW +: RW]);
  endfunction

  // Nearest stage holding a writer of src, 0 if none (register 0 never matches).
  function automatic int nearest(int src);
    for (int p = 1; p <= D; p++)
      if (m_wr[p] && m_dest[p] == src && src != 0) return p;
    return 0;
  endfunction

  // 0: no hazard, 1: result not yet available for a late read, 2: same for an early read.
  function automatic int haz_kind(int k);
    int p;
    p = nearest(src_of(k));
    if (!id_use[k] || p == 0) return 0;
    if (id_early[k]) return (p <= m_rdy[p]) ? 2 : 0;
    return (p < m_rdy[p]) ? 1 : 0;
  endfunction

  function automatic bit exp_stall();
    bit any = 0;
    for (int k = 0; k < NS; k++) if (haz_kind(k) != 0) any = 1;
    return !reset && id_valid && !id_flush && any;
  endfunction

  function automatic bit exp_early_only();
    bit late = 0;
    for (int k = 0; k < NS; k++) if (haz_kind(k) == 1) late = 1;
    return exp_stall() && !late;
  endfunction

  // Advance the model on every clock edge.
  always @(posedge clk) begin
    bit st, iss;
    int nex [NS];
    if (reset) begin
      for (int p = 1; p <= D; p++) begin m_wr[p] = 0; m_dest[p] = 0; m_rdy[p] = 0; end
      for (int k = 0; k < NS; k++) m_ex[k] = 0;
      m_pstall = 0; m_pearly = 0;
    end else if (!ext_stall) begin
      st  = exp_stall();
      iss = id_valid && !st && !id_flush;
      if (st) begin
        if (m_pstall < 64'hFFFF_FFFF) m_pstall++;
        if (exp_early_only() && m_pearly < 64'hFFFF_FFFF) m_pearly++;
      end
      for (int k = 0; k < NS; k++) begin
        int p;
        p = nearest(src_of(k));
        nex[k] = (iss && p > 0 && p < D) ? p + 1 : 0;
      end
      for (int p = D; p > 1; p--) begin
        m_wr[p] = m_wr[p-1]; m_dest[p] = m_dest[p-1]; m_rdy[p] = m_rdy[p-1];
      end
      m_wr[1]   = iss && id_wr_en;
      m_dest[1] = int'(id_wr_dest);
      m_rdy[1]  = int'(id_ready);
      for (int k = 0; k < NS; k++) m_ex[k] = nex[k];
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (run_chk) begin
      bit es;
      es = exp_stall();
      check("m_stall", {31'b0, stall}, {31'b0, es});
      for (int k = 0; k < NS; k++) begin
        if (!es) check("m_id_fwd", 32'(id_fwd_sel[k*DW +: DW]), reset ? 0 : nearest(src_of(k)));
        check("m_ex_fwd", 32'(ex_fwd_sel[k*DW +: DW]), m_ex[k]);
      end
`ifdef HAZARD_PERF_CNT_EN
      check("m_perf_stall", perf_stall_cycles, 32'(m_pstall));
      check("m_perf_early", perf_early_stalls, 32'(m_pearly));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit v, int s0, bit u0, bit e0, bit w, int d, int r,
                        bit fl = 0, bit xs = 0);
    id_valid = v; id_src = '0; id_src[RW-1:0] = RW'(s0);
    id_use = {1'b0, u0}; id_early = {1'b0, e0};
    id_wr_en = w; id_wr_dest = RW'(d); id_ready = DW'(r);
    id_flush = fl; ext_stall = xs;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; idle();
    step(); step();
    reset = 0; run_chk = 1;
    #1;
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_id_fwd", 32'(id_fwd_sel), 0);
    check("rst_ex_fwd", 32'(ex_fwd_sel), 0);

    // ALU producer, back-to-back late reader: MEM->EX forward.
    set_in(1, 0, 0, 0, 1, 3, 1); #1;
    check("alu_prod_stall", {31'b0, stall}, 0);
    step(); set_in(1, 3, 1, 0, 0, 0, 1); #1;
    check("alu_rd_stall", {31'b0, stall}, 0);
    check("alu_rd_id_fwd", 32'(id_fwd_sel[1:0]), 1);
    step(); idle(); #1;
    check("alu_rd_ex_fwd", 32'(ex_fwd_sel[1:0]), 2);
    // Same with one bubble between: WB->EX forward.
    set_in(1, 0, 0, 0, 1, 3, 1); step(); idle(); step();
    set_in(1, 3, 1, 0, 0, 0, 1); #1;
    check("alu_gap_id_fwd", 32'(id_fwd_sel[1:0]), 2);
    step(); idle(); #1;
    check("alu_gap_ex_fwd", 32'(ex_fwd_sel[1:0]), 3);

    // Load-use: one stall cycle.
    set_in(1, 0, 0, 0, 1, 4, 2); step();
    set_in(1, 4, 1, 0, 1, 11, 1); #1;
    check("lu_stall1", {31'b0, stall}, 1);
    step(); #1;
    check("lu_stall2", {31'b0, stall}, 0);
    check("lu_id_fwd", 32'(id_fwd_sel[1:0]), 2);
    step(); idle(); #1;
    check("lu_ex_fwd", 32'(ex_fwd_sel[1:0]), 3);

    // Load then early-use branch: two stall cycles.
    set_in(1, 0, 0, 0, 1, 5, 2); step();
    set_in(1, 5, 1, 1, 0, 0, 1); #1;
    check("ld_br_stall1", {31'b0, stall}, 1);
    step(); #1;
    check("ld_br_stall2", {31'b0, stall}, 1);
    step(); #1;
    check("ld_br_release", {31'b0, stall}, 0);
    check("ld_br_id_fwd", 32'(id_fwd_sel[1:0]), 3);
    step(); idle();

    // Register 0 never matches.
    set_in(1, 0, 0, 0, 1, 0, 2); step();
    set_in(1, 0, 1, 1, 0, 0, 1); #1;
    check("r0_stall", {31'b0, stall}, 0);
    check("r0_id_fwd", 32'(id_fwd_sel), 0);
    step(); idle(); #1;
    check("r0_ex_fwd", 32'(ex_fwd_sel), 0);

    // Load-use stall frozen by ext_stall for three cycles.
    set_in(1, 0, 0, 0, 1, 7, 1); step();
    set_in(1, 7, 1, 0, 1, 6, 2); #1;
    check("frz_ld_id_fwd", 32'(id_fwd_sel[1:0]), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 6, 1, 0, 0, 0, 1, 0, 1); #1;
      check("frz_stall", {31'b0, stall}, 1);
      check("frz_ex_fwd", 32'(ex_fwd_sel[1:0]), 2);
      step();
    end
    set_in(1, 6, 1, 0, 0, 0, 1); #1;
    check("frz_rel_stall", {31'b0, stall}, 1);
    step(); #1;
    check("frz_done_stall", {31'b0, stall}, 0);
    check("frz_done_id_fwd", 32'(id_fwd_sel[1:0]), 2);
    step(); idle();

    // Flush beats stall, and the flushed writer leaves no tag.
    set_in(1, 0, 0, 0, 1, 9, 2); step();
    set_in(1, 9, 1, 0, 1, 10, 1, 1); #1;
    check("fl_stall", {31'b0, stall}, 0);
    step(); set_in(1, 10, 1, 0, 0, 0, 1); #1;
    check("fl_no_tag", 32'(id_fwd_sel[1:0]), 0);
    check("fl_ex_fwd", 32'(ex_fwd_sel[1:0]), 0);
    step(); idle();

    // Reset with a load in EX discards it.
    set_in(1, 0, 0, 0, 1, 8, 2); step();
    reset = 1; idle(); step();
    reset = 0; set_in(1, 8, 1, 1, 0, 0, 1); #1;
    check("rst_mid_stall", {31'b0, stall}, 0);
    check("rst_mid_id_fwd", 32'(id_fwd_sel[1:0]), 0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_perf_stall", perf_stall_cycles, 0);
    check("rst_perf_early", perf_early_stalls, 0);
`endif
    step();

    // Randomized traffic over a small register window.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(99) < 2);
      id_valid   = ($urandom_range(99) < 85);
      id_src     = {RW'($urandom_range(7)), RW'($urandom_range(7))};
      id_use     = NS'($urandom);
      id_early   = NS'($urandom) & NS'($urandom);
      id_wr_en   = ($urandom_range(99) < 70);
      id_wr_dest = RW'($urandom_range(7));
      id_ready   = DW'($urandom_range(D, 1));
      id_flush   = ($urandom_range(99) < 8);
      ext_stall  = ($urandom_range(99) < 15);
      step();
    end
    reset = 0; idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
